buzzer_zone_scheduler: RTL and testbench

- Shares one alarm buzzer among NZONES sensor zones.
- Per zone: debounces the sensor input and latches a sticky pending alarm.
- Round-robin scheduler grants the buzzer to one pending zone at a time for a fixed alert window, followed by a silent gap.
- Sits between the raw sensor pins (ui_in) and the buzzer/zone-indicator pins (uo_out) of the alarm top level.

---
 rtl/buzzer_zone_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_buzzer_zone_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_zone_scheduler.sv
// buzzer_zone_scheduler
// Shares one alarm buzzer among NZONES sensor zones. Each zone input is
// debounced and latches a sticky pending alarm; a round-robin scheduler then
// grants the buzzer to one pending zone for ALERT_CYCLES, followed by a
// silent gap of GAP_CYCLES before the next grant.
// Optional feature: define BUZZ_PATTERN_EN to make the buzzer sound a
// zone-specific on/off pattern (buzz = ~alert_cnt[zone]) during ALERT.
// All outputs are registered; ena=0 freezes every register.

module buzzer_zone_scheduler #(
    parameter int NZONES       = 3,
    parameter int DEB_CYCLES   = 7,
    parameter int ALERT_CYCLES = 31,
    parameter int GAP_CYCLES   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NZONES-1:0] zone_in,
    input  logic [NZONES-1:0] clear_i,
    output logic              buzz_o,
    output logic [NZONES-1:0] grant_o,
    output logic [NZONES-1:0] pending_o,
    output logic              busy_o
);

    localparam int PW = (NZONES > 1) ? $clog2(NZONES) : 1;

    localparam logic [7:0]    DEB_MAX    = 8'(DEB_CYCLES);
    localparam logic [7:0]    ALERT_LAST = 8'(ALERT_CYCLES - 1);
    localparam logic [7:0]    GAP_LAST   = 8'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] PTR_INIT   = PW'(NZONES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALERT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [7:0]        deb_cnt  [NZONES];
    logic [7:0]        deb_next [NZONES];
    logic [NZONES-1:0] deb_set;
    logic [NZONES-1:0] pending_next;

    logic [7:0]        alert_cnt;
    logic [7:0]        alert_next;
    logic [7:0]        gap_cnt;
    logic [7:0]        gap_next;

    logic [PW-1:0]     last_grant;
    logic [PW-1:0]     last_next;
    logic [PW-1:0]     sel_idx;
    logic              sel_found;

    logic [NZONES-1:0] grant_next;
    logic              buzz_next;
    logic              busy_next;
    logic              abort_req;

    // Per-zone debounce counters and the sticky pending alarm bits; a set
    // caused by the counter reaching DEB_MAX overrides a same-cycle clear.
    always_comb begin
        for (int i = 0; i < NZONES; i++) begin
            deb_next[i] = deb_cnt[i];
            deb_set[i]  = 1'b0;
            if (!zone_in[i]) begin
                deb_next[i] = 8'd0;
            end else if (deb_cnt[i] != DEB_MAX) begin
                deb_next[i] = deb_cnt[i] + 8'd1;
                deb_set[i]  = ((deb_cnt[i] + 8'd1) == DEB_MAX);
            end
        end
        pending_next = (pending_o & ~clear_i) | deb_set;
    end

    // Round-robin pick: first pending zone after last_grant, wrapping around.
    always_comb begin
        int            idx;
        logic [PW-1:0] idx_p;
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        idx_p     = '0;
        for (int k = 1; k <= NZONES; k++) begin
            idx   = (int'(last_grant) + k) % NZONES;
            idx_p = PW'(idx);
            if (!sel_found && pending_o[idx_p]) begin
                sel_found = 1'b1;
                sel_idx   = idx_p;
            end
        end
    end

    // FSM next state plus the next values of the registered outputs.
    always_comb begin
        logic [2:0] pat_idx;
        state_next = state;
        alert_next = alert_cnt;
        gap_next   = gap_cnt;
        last_next  = last_grant;
        grant_next = grant_o;
        buzz_next  = 1'b0;
        busy_next  = 1'b0;
        abort_req  = |(clear_i & grant_o);
        pat_idx    = '0;

        case (state)
            IDLE: begin
                grant_next = '0;
                if (sel_found) begin
                    state_next = ALERT;
                    last_next  = sel_idx;
                    alert_next = 8'd0;
                    grant_next = {{(NZONES-1){1'b0}}, 1'b1} << sel_idx;
                end
            end
            ALERT: begin
                if (abort_req || (alert_cnt == ALERT_LAST)) begin
                    state_next = GAP;
                    gap_next   = 8'd0;
                    grant_next = '0;
                end else begin
                    alert_next = alert_cnt + 8'd1;
                end
            end
            GAP: begin
                grant_next = '0;
                if (gap_cnt == GAP_LAST) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_cnt + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase

        busy_next = (state_next != IDLE);
        pat_idx   = 3'(last_next);
        if (state_next == ALERT) begin
`ifdef BUZZ_PATTERN_EN
            buzz_next = ~alert_next[pat_idx];
`else
            buzz_next = 1'b1;
`endif
        end
    end

    // State, counters and output registers; everything holds while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            alert_cnt  <= 8'd0;
            gap_cnt    <= 8'd0;
            last_grant <= PTR_INIT;
            pending_o  <= '0;
            grant_o    <= '0;
            buzz_o     <= 1'b0;
            busy_o     <= 1'b0;
            for (int i = 0; i < NZONES; i++) begin
                deb_cnt[i] <= 8'd0;
            end
        end else if (ena) begin
            state      <= state_next;
            alert_cnt  <= alert_next;
            gap_cnt    <= gap_next;
            last_grant <= last_next;
            pending_o  <= pending_next;
            grant_o    <= grant_next;
            buzz_o     <= buzz_next;
            busy_o     <= busy_next;
            for (int i = 0; i < NZONES; i++) begin
                deb_cnt[i] <= deb_next[i];
            end
        end
    end

endmodule

// File: tb/tb_buzzer_zone_scheduler.sv
// Directed self-checking bench for buzzer_zone_scheduler (default parameters).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_buzzer_zone_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [2:0] zone_in;
    logic [2:0] clear_i;
    logic       buzz_o;
    logic [2:0] grant_o;
    logic [2:0] pending_o;
    logic       busy_o;

    int total = 0;
    int bad   = 0;

    int len;
    int hi;
    logic saw_any;
    logic [5:0] pat_exp;

    buzzer_zone_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .zone_in  (zone_in),
        .clear_i  (clear_i),
        .buzz_o   (buzz_o),
        .grant_o  (grant_o),
        .pending_o(pending_o),
        .busy_o   (busy_o)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive zone/clear inputs and advance n edges.
    task automatic applyStimulus(input logic [2:0] z, input logic [2:0] c, input int n);
        zone_in = z;
        clear_i = c;
        tick(n);
    endtask

    // One counted comparison.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Count samples while a zone is granted, plus how many had buzz high.
    task automatic measureAlert(output int n, output int h);
        n = 0;
        h = 0;
        while ((grant_o !== 3'b000) && (n < 300)) begin
            n++;
            if (buzz_o === 1'b1) h++;
            tick();
        end
    endtask

    // Count samples with no grant (gap + idle), plus any buzz-high samples.
    task automatic measureGap(output int n, output int h);
        n = 0;
        h = 0;
        while ((grant_o === 3'b000) && (n < 100)) begin
            n++;
            if (buzz_o === 1'b1) h++;
            tick();
        end
    endtask

    task automatic doReset();
        rst_n   = 1'b0;
        zone_in = 3'b000;
        clear_i = 3'b000;
        ena     = 1'b1;
        tick(2);
        rst_n   = 1'b1;
    endtask

    initial begin
        // ---------------- reset state
        doReset();
        checkOutput("rst_buzz",    32'(buzz_o),    32'h0);
        checkOutput("rst_grant",   32'(grant_o),   32'h0);
        checkOutput("rst_pending", 32'(pending_o), 32'h0);
        checkOutput("rst_busy",    32'(busy_o),    32'h0);

        // ---------------- zone 1 debounce, alert, gap, re-grant
        applyStimulus(3'b010, 3'b000, 6);
        checkOutput("deb_6_pending", 32'(pending_o), 32'h0);
        applyStimulus(3'b010, 3'b000, 1);
        checkOutput("deb_7_pending", 32'(pending_o), 32'h2);
        checkOutput("deb_7_nogrant", 32'(grant_o),   32'h0);
        applyStimulus(3'b000, 3'b000, 1);
        checkOutput("z1_grant", 32'(grant_o), 32'h2);
        checkOutput("z1_buzz",  32'(buzz_o),  32'h1);
        checkOutput("z1_busy",  32'(busy_o),  32'h1);
        measureAlert(len, hi);
        checkOutput("z1_alert_len", 32'(len), 32'd31);
`ifdef BUZZ_PATTERN_EN
        checkOutput("z1_buzz_hi", 32'(hi), 32'd16);
`else
        checkOutput("z1_buzz_hi", 32'(hi), 32'd31);
`endif
        measureGap(len, hi);
        checkOutput("z1_gap_len",     32'(len), 32'd5);
        checkOutput("z1_gap_buzz",    32'(hi),  32'd0);
        checkOutput("z1_regrant",     32'(grant_o), 32'h2);

        // abort the re-grant with a clear of the granted zone
        applyStimulus(3'b000, 3'b010, 1);
        clear_i = 3'b000;
        checkOutput("abort_buzz",    32'(buzz_o),    32'h0);
        checkOutput("abort_grant",   32'(grant_o),   32'h0);
        checkOutput("abort_pending", 32'(pending_o), 32'h0);
        checkOutput("abort_busy",    32'(busy_o),    32'h1);
        tick(3);
        checkOutput("gap_end_busy",  32'(busy_o),    32'h1);
        tick(1);
        checkOutput("idle_busy",     32'(busy_o),    32'h0);
        tick(2);
        checkOutput("idle_grant",    32'(grant_o),   32'h0);

        // ---------------- glitchy zone 0 never qualifies
        saw_any = 1'b0;
        for (int s = 0; s < 14; s++) begin
            zone_in = ((s == 6) || (s == 13)) ? 3'b000 : 3'b001;
            tick();
            saw_any = saw_any | buzz_o | (|pending_o);
        end
        checkOutput("glitch_pending", 32'(pending_o), 32'h0);
        checkOutput("glitch_nobuzz",  32'(saw_any),   32'h0);

        // ---------------- all zones pending, round robin from zone 0
        doReset();
        applyStimulus(3'b111, 3'b000, 7);
        checkOutput("all_pending", 32'(pending_o), 32'h7);
        applyStimulus(3'b000, 3'b000, 1);
        checkOutput("rr_first", 32'(grant_o), 32'h1);
        measureAlert(len, hi);
        checkOutput("rr_first_len", 32'(len), 32'd31);
        measureGap(len, hi);
        checkOutput("rr_gap1_len", 32'(len), 32'd5);
        checkOutput("rr_second", 32'(grant_o), 32'h2);
        measureAlert(len, hi);
        checkOutput("rr_second_len", 32'(len), 32'd31);
        measureGap(len, hi);
        checkOutput("rr_gap2_len", 32'(len), 32'd5);
        checkOutput("rr_third", 32'(grant_o), 32'h4);
        checkOutput("rr_pending_kept", 32'(pending_o), 32'h7);

        // abort zone 2 at alert cycle 10
        tick(10);
        checkOutput("z2_still_on", 32'(grant_o), 32'h4);
        applyStimulus(3'b000, 3'b100, 1);
        clear_i = 3'b000;
        checkOutput("z2_abort_grant",   32'(grant_o),   32'h0);
        checkOutput("z2_abort_buzz",    32'(buzz_o),    32'h0);
        checkOutput("z2_abort_pending", 32'(pending_o), 32'h3);
        measureGap(len, hi);
        checkOutput("z2_abort_gap_len", 32'(len), 32'd5);
        checkOutput("after_abort_grant", 32'(grant_o), 32'h1);

        // ---------------- set wins over clear, then ena freeze mid-alert
        doReset();
        applyStimulus(3'b001, 3'b000, 6);
        applyStimulus(3'b001, 3'b001, 1);
        zone_in = 3'b000;
        clear_i = 3'b000;
        checkOutput("set_wins", 32'(pending_o), 32'h1);
        tick();
        checkOutput("sw_grant", 32'(grant_o), 32'h1);
        tick(10);
        ena = 1'b0;
        applyStimulus(3'b010, 3'b000, 20);
        zone_in = 3'b000;
        checkOutput("frozen_grant",   32'(grant_o),   32'h1);
        checkOutput("frozen_buzz",    32'(buzz_o),    32'h1);
        checkOutput("frozen_busy",    32'(busy_o),    32'h1);
        checkOutput("frozen_pending", 32'(pending_o), 32'h1);
        ena = 1'b1;
        measureAlert(len, hi);
        checkOutput("resume_alert_len", 32'(len), 32'd21);

        // ---------------- asynchronous reset mid-alert
        measureGap(len, hi);
        checkOutput("pre_rst_grant", 32'(grant_o), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_buzz",    32'(buzz_o),    32'h0);
        checkOutput("arst_grant",   32'(grant_o),   32'h0);
        checkOutput("arst_pending", 32'(pending_o), 32'h0);
        checkOutput("arst_busy",    32'(busy_o),    32'h0);
        tick();
        rst_n = 1'b1;

        // ---------------- zone 1 buzz pattern over first alert samples
`ifdef BUZZ_PATTERN_EN
        pat_exp = 6'b110011;
`else
        pat_exp = 6'b111111;
`endif
        applyStimulus(3'b010, 3'b000, 7);
        applyStimulus(3'b000, 3'b000, 1);
        for (int j = 0; j < 6; j++) begin
            checkOutput($sformatf("pattern_%0d", j), 32'(buzz_o), 32'(pat_exp[5-j]));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
